display_source_arbiter: RTL and testbench
=========================================

// Module: display_source_arbiter
// PURPOSE
//  Shares the 4-digit multiplexed LED display between the clock's display sources: running
//  time (default), alarm edit and stopwatch. Fixed-priority, request-held grants; an
//  idle-timeout on alarm edit; blinking of the digits under edit. Drives the four digit
//  bytes consumed by the LED scan/multiplex unit.
// PARAMETERS
//  BLINK_DIV    12_500_000  cycles per blink half-period (50 MHz -> 4 Hz toggle)
//  TIMEOUT_CYC  500_000_000 alarm-edit cycles without alarm_act before forced revert (10 s)
// PORTS
//  clk            in   1   system clock, 50 MHz
//  rst_n          in   1   asynchronous active-low reset
//  time_digits    in   32  time source; [7:0]=digit1 ... [31:24]=digit4, 7-seg+DP, active-low
//  alarm_req      in   1   alarm-edit source requests display (level, held while editing)
//  alarm_act      in   1   1-cycle pulse on any alarm-edit key press; restarts idle timer
//  alarm_digits   in   32  alarm source digit bytes, same packing as time_digits
//  alarm_blink    in   4   digits under edit; bit i -> digit i+1
//  sw_req         in   1   stopwatch requests display (level)
//  sw_digits      in   32  stopwatch digit bytes
//  grant          out  3   one-hot owner: 001=time, 010=alarm, 100=stopwatch
//  led1..led4     out  8   digit bytes to the LED multiplex unit, active-low (8'hFF = blank)
//  timeout_pulse  out  1   1-cycle pulse when alarm edit is forcibly revoked
// BEHAVIOUR
//  Reset (async, rst_n=0): state TIME, grant=001, led1..4=8'hFF, timeout_pulse=0,
//   idle counter=0, blink counter=0, blink_on=1, alarm_lock=0.
//  FSM (registered; grant = one-hot decode of state):
//   TIME : alarm_req & !alarm_lock -> ALARM; else sw_req -> SW; else stay.
//   SW   : alarm_req & !alarm_lock -> ALARM (preempts stopwatch); else !sw_req -> TIME.
//   ALARM: idle counter == TIMEOUT_CYC-1 & !alarm_act -> TIME, set alarm_lock,
//          timeout_pulse=1 for the next cycle only;
//          else !alarm_req -> SW if sw_req, else TIME.
//  Latency: requests sampled at edge n -> grant changes at edge n+1 -> led1..4 show the
//   new source at edge n+2. led outputs are always registered; no combinational
//   input-to-output path.
//  alarm_lock: once set, alarm_req is ignored until alarm_req is sampled low; the lock
//   clears on that cycle. A held alarm_req therefore cannot re-grab the display after
//   a timeout.
//  Idle counter: cleared on entry to ALARM and on every alarm_act; increments each ALARM
//   cycle. alarm_act and expiry in the same cycle: alarm_act wins, no timeout.
//   Counter width is sufficient for TIMEOUT_CYC; it never wraps.
//  Blink: counter runs 0..BLINK_DIV-1 and wraps. blink_on toggles at each wrap.
//   Counter clears and blink_on is forced to 1 on any grant change, so an edited digit
//   is visible at once.
//  Output mux: TIME -> time_digits; SW -> sw_digits; ALARM -> alarm_digits, except
//   digit i is 8'hFF when alarm_blink[i] & !blink_on.
//   alarm_blink is ignored in TIME and SW.
//  Simultaneous alarm_req and sw_req from TIME: ALARM wins. sw_req dropping during
//   ALARM has no effect.
//  Inputs are synchronous to clk; digit buses are sampled every cycle (live updates
//   pass through at 1-cycle latency).
// TESTING (bench uses BLINK_DIV=4, TIMEOUT_CYC=10)
//  Reset: rst_n=0 mid-ALARM -> grant=001, led1..4=FF immediately (async);
//   after release, led1..4 = time_digits 1 cycle later.
//  Priority: alarm_req=sw_req=1 at edge n -> grant=010 at n+1, led=alarm_digits at n+2;
//   drop alarm_req -> grant=100 next edge; drop sw_req -> grant=001.
//  Preempt: sw_req=1 (grant=100), then alarm_req=1 -> grant=010 next edge; alarm_req=0
//   with sw_req=1 -> grant=100.
//  Blink: ALARM, alarm_blink=4'b0011, digits=32'h12345678 -> led1/led2 alternate
//   78/FF and 56/FF every 4 cycles, visible first; led3=34 and led4=12 steady.
//  Timeout: alarm_req held, no alarm_act for 10 cycles -> grant=001, timeout_pulse high
//   1 cycle; grant stays 001 while alarm_req high. alarm_req 0 for 1 cycle, then 1 ->
//   grant=010.
//  Act vs expiry: alarm_act on the 10th idle cycle -> no timeout, counter restarts,
//   expiry 10 cycles later.

Source files
------------

// File: rtl/display_source_arbiter.sv
// Selects which clock source (time / alarm edit / stopwatch) owns the 4-digit LED display,
// with alarm-edit idle timeout, re-grab lockout and blinking of edited digits.
module display_source_arbiter #(
    parameter int unsigned BLINK_DIV   = 12_500_000,
    parameter int unsigned TIMEOUT_CYC = 500_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] time_digits,
    input  logic        alarm_req,
    input  logic        alarm_act,
    input  logic [31:0] alarm_digits,
    input  logic [3:0]  alarm_blink,
    input  logic        sw_req,
    input  logic [31:0] sw_digits,
    output logic [2:0]  grant,
    output logic [7:0]  led1,
    output logic [7:0]  led2,
    output logic [7:0]  led3,
    output logic [7:0]  led4,
    output logic        timeout_pulse
);

    localparam int unsigned IDLE_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(TIMEOUT_CYC - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        S_TIME  = 2'd0,
        S_ALARM = 2'd1,
        S_SW    = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IDLE_W-1:0]    idle_q, idle_d;
    logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
    logic                 blink_on_q, blink_on_d;
    logic                 lock_q, lock_d;
    logic                 timeout_q, timeout_d;
    logic [31:0]          led_q, led_d;
    logic [3:0]           blank;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_TIME;
            idle_q      <= '0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
            lock_q      <= 1'b0;
            timeout_q   <= 1'b0;
            led_q       <= '1;
        end else begin
            state_q     <= state_d;
            idle_q      <= idle_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
            lock_q      <= lock_d;
            timeout_q   <= timeout_d;
            led_q       <= led_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timeout_d = 1'b0;
        lock_d    = alarm_req ? lock_q : 1'b0;
        idle_d    = idle_q;
        case (state_q)
            S_TIME: begin
                if (alarm_req && !lock_q) state_d = S_ALARM;
                else if (sw_req)          state_d = S_SW;
            end
            S_SW: begin
                if (alarm_req && !lock_q) state_d = S_ALARM;
                else if (!sw_req)         state_d = S_TIME;
            end
            S_ALARM: begin
                if (idle_q == IDLE_LAST && !alarm_act) begin
                    state_d   = S_TIME;
                    timeout_d = 1'b1;
                    lock_d    = 1'b1;
                end else if (!alarm_req) begin
                    state_d = sw_req ? S_SW : S_TIME;
                end
            end
            default: state_d = S_TIME;
        endcase

        // Saturate at the last count so the timer never wraps on the exit cycle.
        if (state_q == S_ALARM) begin
            if (alarm_act)                idle_d = '0;
            else if (idle_q != IDLE_LAST) idle_d = idle_q + IDLE_W'(1);
        end
        if (state_d == S_ALARM && state_q != S_ALARM) idle_d = '0;
    end

    always_comb begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        blink_on_d  = blink_on_q;
        if (state_d != state_q) begin
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_on_d  = ~blink_on_q;
        end
    end

    // Blanked digits are all-ones, so OR-ing a per-byte mask blanks them.
    always_comb begin
        blank = alarm_blink & {4{~blink_on_q}};
        case (state_q)
            S_ALARM: led_d = alarm_digits | {{8{blank[3]}}, {8{blank[2]}},
                                             {8{blank[1]}}, {8{blank[0]}}};
            S_SW:    led_d = sw_digits;
            default: led_d = time_digits;
        endcase
    end

    always_comb begin
        case (state_q)
            S_ALARM: grant = 3'b010;
            S_SW:    grant = 3'b100;
            default: grant = 3'b001;
        endcase
    end

    assign led1          = led_q[7:0];
    assign led2          = led_q[15:8];
    assign led3          = led_q[23:16];
    assign led4          = led_q[31:24];
    assign timeout_pulse = timeout_q;

endmodule

// File: tb/tb_display_source_arbiter.sv
// Directed bench for display_source_arbiter: table-driven grant/mux vectors plus
// hand sequences for blink, timeout, lockout, act-vs-expiry and async reset.
module tb_display_source_arbiter;

    localparam logic [31:0] T_DIG = 32'hC0F9A4B0;
    localparam logic [31:0] A_DIG = 32'h12345678;
    localparam logic [31:0] S_DIG = 32'hA1B2C3D4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] time_digits, alarm_digits, sw_digits;
    logic        alarm_req, alarm_act, sw_req;
    logic [3:0]  alarm_blink;
    logic [2:0]  grant;
    logic [7:0]  led1, led2, led3, led4;
    logic        timeout_pulse;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        ar;
        logic        sr;
        logic [2:0]  g;
        logic [31:0] led;
    } vec_t;

    vec_t vecs [13];

    display_source_arbiter #(.BLINK_DIV(4), .TIMEOUT_CYC(10)) dut (
        .clk(clk), .rst_n(rst_n), .time_digits(time_digits),
        .alarm_req(alarm_req), .alarm_act(alarm_act), .alarm_digits(alarm_digits),
        .alarm_blink(alarm_blink), .sw_req(sw_req), .sw_digits(sw_digits),
        .grant(grant), .led1(led1), .led2(led2), .led3(led3), .led4(led4),
        .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] leds();
        return {led4, led3, led2, led1};
    endfunction

    initial begin
        rst_n        = 1'b0;
        time_digits  = T_DIG;
        alarm_digits = A_DIG;
        sw_digits    = S_DIG;
        alarm_req    = 1'b0;
        alarm_act    = 1'b0;
        sw_req       = 1'b0;
        alarm_blink  = 4'b0000;

        // Rows: inputs before an edge, grant/leds after it (leds follow the previous grant).
        vecs[0]  = '{ar:1'b0, sr:1'b0, g:3'b001, led:T_DIG};
        vecs[1]  = '{ar:1'b1, sr:1'b1, g:3'b010, led:T_DIG};
        vecs[2]  = '{ar:1'b1, sr:1'b0, g:3'b010, led:A_DIG};
        vecs[3]  = '{ar:1'b0, sr:1'b1, g:3'b100, led:A_DIG};
        vecs[4]  = '{ar:1'b0, sr:1'b1, g:3'b100, led:S_DIG};
        vecs[5]  = '{ar:1'b0, sr:1'b0, g:3'b001, led:S_DIG};
        vecs[6]  = '{ar:1'b0, sr:1'b0, g:3'b001, led:T_DIG};
        vecs[7]  = '{ar:1'b0, sr:1'b1, g:3'b100, led:T_DIG};
        vecs[8]  = '{ar:1'b0, sr:1'b1, g:3'b100, led:S_DIG};
        vecs[9]  = '{ar:1'b1, sr:1'b1, g:3'b010, led:S_DIG};
        vecs[10] = '{ar:1'b1, sr:1'b1, g:3'b010, led:A_DIG};
        vecs[11] = '{ar:1'b0, sr:1'b1, g:3'b100, led:A_DIG};
        vecs[12] = '{ar:1'b0, sr:1'b0, g:3'b001, led:S_DIG};

        repeat (2) step();
        chk("reset_grant", {29'd0, grant}, 32'h1);
        chk("reset_led", leds(), 32'hFFFFFFFF);
        chk("reset_tp", {31'd0, timeout_pulse}, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            alarm_req = vecs[i].ar;
            sw_req    = vecs[i].sr;
            step();
            chk($sformatf("vec%0d_grant", i), {29'd0, grant}, {29'd0, vecs[i].g});
            chk($sformatf("vec%0d_led", i), leds(), vecs[i].led);
            chk($sformatf("vec%0d_tp", i), {31'd0, timeout_pulse}, 32'h0);
        end
        sw_req = 1'b0;
        step();

        // Live digit update passes through with one cycle of latency.
        time_digits = 32'h99887766;
        step();
        chk("live_time_led", leds(), 32'h99887766);
        time_digits = T_DIG;
        step();

        // Blink: alarm_act keeps the idle timer clear throughout.
        alarm_req   = 1'b1;
        alarm_act   = 1'b1;
        alarm_blink = 4'b0011;
        step();
        chk("blink_grant", {29'd0, grant}, 32'h2);
        for (int k = 1; k <= 12; k++) begin
            step();
            chk($sformatf("blink_led_k%0d", k), leds(),
                ((((k - 1) / 4) % 2) == 0) ? 32'h12345678 : 32'h1234FFFF);
        end
        alarm_req = 1'b0;
        alarm_act = 1'b0;
        step();
        chk("blink_exit_grant", {29'd0, grant}, 32'h1);
        step();
        chk("blink_exit_led", leds(), T_DIG);

        // Timeout with alarm_req held, then lockout and re-grab.
        alarm_req = 1'b1;
        step();
        chk("to_entry_grant", {29'd0, grant}, 32'h2);
        for (int k = 1; k <= 13; k++) begin
            step();
            chk($sformatf("to_grant_k%0d", k), {29'd0, grant}, (k < 10) ? 32'h2 : 32'h1);
            chk($sformatf("to_pulse_k%0d", k), {31'd0, timeout_pulse}, (k == 10) ? 32'h1 : 32'h0);
        end
        chk("to_led_blank_ignored", leds(), T_DIG);
        alarm_req = 1'b0;
        step();
        chk("lock_clear_grant", {29'd0, grant}, 32'h1);
        alarm_req = 1'b1;
        step();
        chk("regrab_grant", {29'd0, grant}, 32'h2);
        alarm_req = 1'b0;
        step();
        chk("regrab_exit_grant", {29'd0, grant}, 32'h1);

        // alarm_act on the expiry cycle wins and restarts the full idle period.
        alarm_req = 1'b1;
        step();
        for (int k = 1; k <= 9; k++) step();
        chk("act_pre_grant", {29'd0, grant}, 32'h2);
        alarm_act = 1'b1;
        step();
        alarm_act = 1'b0;
        chk("act_win_grant", {29'd0, grant}, 32'h2);
        chk("act_win_tp", {31'd0, timeout_pulse}, 32'h0);
        for (int j = 1; j <= 10; j++) begin
            step();
            chk($sformatf("act_restart_grant_j%0d", j), {29'd0, grant}, (j < 10) ? 32'h2 : 32'h1);
            chk($sformatf("act_restart_tp_j%0d", j), {31'd0, timeout_pulse}, (j == 10) ? 32'h1 : 32'h0);
        end
        alarm_req = 1'b0;
        step();

        // Async reset mid-ALARM.
        alarm_req = 1'b1;
        step();
        step();
        chk("pre_rst_led", leds(), A_DIG);
        rst_n = 1'b0;
        #1;
        chk("async_rst_grant", {29'd0, grant}, 32'h1);
        chk("async_rst_led", leds(), 32'hFFFFFFFF);
        alarm_req = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
        chk("post_rst_grant", {29'd0, grant}, 32'h1);
        chk("post_rst_led", leds(), T_DIG);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
